// File: rtl/ahbl_to_apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB bridge. The bridge connects through the slave modport.
// The master modport is the view of the surrounding AHB requester and APB target.
interface ahbl_to_apb_bridge_if #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
);
  logic               ahbls_hready;
  logic               ahbls_hready_resp;
  logic               ahbls_hresp;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic               ahbls_hwrite;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize;
  logic               ahbls_hsel;
  logic [W_DATA-1:0]  ahbls_hwdata;
  logic [W_DATA-1:0]  ahbls_hrdata;
  logic [W_DATA-1:0]  ahbls_hartid;
  logic [31:0]        ahbls_pd_pc;
  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel;
  logic               apbm_penable;
  logic               apbm_pwrite;
  logic [W_DATA-1:0]  apbm_pwdata;
  logic               apbm_pready;
  logic [W_DATA-1:0]  apbm_prdata;
  logic               apbm_pslverr;
  logic [W_DATA-1:0]  apbm_phartid;
  logic [31:0]        apbm_pd_pc;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hsel,
    input  ahbls_hwdata, ahbls_hartid, ahbls_pd_pc,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata, apbm_phartid, apbm_pd_pc,
    input  apbm_pready, apbm_prdata, apbm_pslverr
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hsel,
    output ahbls_hwdata, ahbls_hartid, ahbls_pd_pc,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata, apbm_phartid, apbm_pd_pc,
    output apbm_pready, apbm_prdata, apbm_pslverr
  );
endinterface

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS transfer per AHB transfer,
// AHB data phase stretched until pready, two-cycle AHB ERROR on pslverr.
module ahbl_to_apb_bridge #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ahbl_to_apb_bridge_if.slave  bus
);
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_DATA  = 3'd1;
  localparam logic [2:0] ST_RD_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_SETUP = 3'd3;
  localparam logic [2:0] ST_ACCESS   = 3'd4;
  localparam logic [2:0] ST_ERR1     = 3'd5;
  localparam logic [2:0] ST_ERR2     = 3'd6;

  // Output flags {psel, penable, hready_resp, hresp} for the state being entered
  function automatic logic [3:0] state_flags(input logic [2:0] st);
    logic [3:0] flags;
    case (st)
      ST_IDLE:     flags = 4'b0010;
      ST_WR_DATA:  flags = 4'b0000;
      ST_RD_SETUP: flags = 4'b1000;
      ST_WR_SETUP: flags = 4'b1000;
      ST_ACCESS:   flags = 4'b1100;
      ST_ERR1:     flags = 4'b0001;
      ST_ERR2:     flags = 4'b0011;
      default:     flags = 4'b0010;
    endcase
    return flags;
  endfunction

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [3:0]         flags_r;
  logic               accept_s;
  logic               take_s;
  logic               rd_done_s;
  logic [W_PADDR-1:0] paddr_r;
  logic               pwrite_r;
  logic [W_DATA-1:0]  pwdata_r;
  logic [W_DATA-1:0]  hrdata_r;
  logic [W_DATA-1:0]  phartid_r;
  logic [31:0]        pd_pc_r;
  logic               unused_s;

  assign unused_s  = ^{bus.ahbls_haddr[W_HADDR-1:W_PADDR], bus.ahbls_htrans[0], bus.ahbls_hsize};
  assign accept_s  = bus.ahbls_hready & bus.ahbls_hsel & bus.ahbls_htrans[1];
  // A new address phase is only looked at while this slave is presenting hready_resp=1
  assign take_s    = accept_s & ((state_r == ST_IDLE) | (state_r == ST_ERR2));
  assign rd_done_s = (state_r == ST_ACCESS) & bus.apbm_pready & ~bus.apbm_pslverr & ~pwrite_r;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (take_s) begin
          state_nxt_s = bus.ahbls_hwrite ? ST_WR_DATA : ST_RD_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_DATA:  state_nxt_s = ST_WR_SETUP;
      ST_RD_SETUP: state_nxt_s = ST_ACCESS;
      ST_WR_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.apbm_pready) begin
          state_nxt_s = bus.apbm_pslverr ? ST_ERR1 : ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_ERR1:     state_nxt_s = ST_ERR2;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // State and handshake flags; flags are registered alongside the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      flags_r <= 4'b0010;
    end else begin
      state_r <= state_nxt_s;
      flags_r <= state_flags(state_nxt_s);
    end
  end

  // Address-phase capture, write data latch and read data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_r   <= '0;
      pwrite_r  <= 1'b0;
      pwdata_r  <= '0;
      hrdata_r  <= '0;
      phartid_r <= '0;
      pd_pc_r   <= 32'h0;
    end else begin
      if (take_s) begin
        paddr_r   <= bus.ahbls_haddr[W_PADDR-1:0];
        pwrite_r  <= bus.ahbls_hwrite;
        phartid_r <= bus.ahbls_hartid;
        pd_pc_r   <= bus.ahbls_pd_pc;
      end
      if (state_r == ST_WR_DATA) begin
        pwdata_r <= bus.ahbls_hwdata;
      end
      if (rd_done_s) begin
        hrdata_r <= bus.apbm_prdata;
      end
    end
  end

  assign bus.apbm_psel         = flags_r[3];
  assign bus.apbm_penable      = flags_r[2];
  assign bus.ahbls_hready_resp = flags_r[1];
  assign bus.ahbls_hresp       = flags_r[0];
  assign bus.apbm_paddr        = paddr_r;
  assign bus.apbm_pwrite       = pwrite_r;
  assign bus.apbm_pwdata       = pwdata_r;
  assign bus.ahbls_hrdata      = hrdata_r;
  assign bus.apbm_phartid      = phartid_r;
  assign bus.apbm_pd_pc        = pd_pc_r;
endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Self-checking bench for ahbl_to_apb_bridge: directed vector table, hand sequences
// for idle/reset corners, and randomized transfers against a transaction-level model.
module tb_ahbl_to_apb_bridge;
  logic clk;
  logic rst_n;
  logic hready_blk;
  int   checks;
  int   errors;
  logic [31:0] hrdata_exp;

  ahbl_to_apb_bridge_if #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) bus ();

  ahbl_to_apb_bridge #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single slave on the bus: global HREADY follows this slave unless a test holds it low
  assign bus.ahbls_hready = bus.ahbls_hready_resp & ~hready_blk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic        err;
    int          exp_low;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One AHB transfer issued in the current cycle, with the bench acting as APB target
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int nwait, input logic err,
                         input int exp_low);
    logic [31:0] hid;
    logic [31:0] pc;
    int low, nsel, nen, nerr, acc;
    bit done;
    hid = $urandom;
    pc  = $urandom;
    bus.ahbls_hsel   = 1'b1;
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_haddr  = addr;
    bus.ahbls_hwrite = wr;
    bus.ahbls_hsize  = 3'($urandom);
    bus.ahbls_hartid = hid;
    bus.ahbls_pd_pc  = pc;
    step();
    bus.ahbls_hsel   = 1'b0;
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_haddr  = $urandom;
    bus.ahbls_hwrite = 1'($urandom);
    bus.ahbls_hartid = $urandom;
    bus.ahbls_pd_pc  = $urandom;
    bus.ahbls_hwdata = wdata;
    low = 0; nsel = 0; nen = 0; nerr = 0; acc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (bus.ahbls_hready_resp) begin
        done = 1'b1;
      end else begin
        low++;
        if (bus.ahbls_hresp) nerr++;
        bus.apbm_pready  = 1'($urandom);
        bus.apbm_pslverr = 1'($urandom);
        bus.apbm_prdata  = $urandom;
        if (bus.apbm_psel) begin
          nsel++;
          chk("paddr", 32'(bus.apbm_paddr), {16'h0, addr[15:0]});
          chk("pwrite", 32'(bus.apbm_pwrite), 32'(wr));
          chk("phartid", bus.apbm_phartid, hid);
          chk("pd_pc", bus.apbm_pd_pc, pc);
          if (wr) chk("pwdata", bus.apbm_pwdata, wdata);
          if (bus.apbm_penable) begin
            nen++;
            bus.apbm_pready = (acc == nwait);
            if (acc == nwait) begin
              bus.apbm_prdata  = rdata;
              bus.apbm_pslverr = err;
            end
            acc++;
          end
        end
        step();
        bus.ahbls_hwdata = $urandom;
      end
    end
    bus.apbm_pready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for hready_resp addr=%h", addr);
    end
    if (!wr && !err) hrdata_exp = rdata;
    chk("hready_low_cycles", 32'(low), 32'(exp_low));
    chk("psel_cycles", 32'(nsel), 32'(2 + nwait));
    chk("penable_cycles", 32'(nen), 32'(1 + nwait));
    chk("hresp_low_cycles", 32'(nerr), 32'(err));
    chk("hresp_final", 32'(bus.ahbls_hresp), 32'(err));
    chk("psel_final", 32'(bus.apbm_psel), 32'h0);
    chk("hrdata", bus.ahbls_hrdata, hrdata_exp);
  endtask

  // Cycles with no acceptable request: bridge must stay idle and zero-wait OKAY
  task automatic idle_cycles(input logic sel, input logic [1:0] trans, input logic blk);
    bus.ahbls_hsel   = sel;
    bus.ahbls_htrans = trans;
    bus.ahbls_haddr  = $urandom;
    bus.ahbls_hwrite = 1'($urandom);
    hready_blk       = blk;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_psel", 32'(bus.apbm_psel), 32'h0);
      chk("idle_hready_resp", 32'(bus.ahbls_hready_resp), 32'h1);
      chk("idle_hresp", 32'(bus.ahbls_hresp), 32'h0);
    end
    bus.ahbls_hsel   = 1'b0;
    bus.ahbls_htrans = 2'b00;
    hready_blk       = 1'b0;
  endtask

  initial begin
    logic wr, err;
    int   nw;
    checks = 0; errors = 0; hrdata_exp = 32'h0;
    tbl[0] = '{1'b0, 32'h0000_2004, 32'h0000_0000, 32'hCAFE_F00D, 0, 1'b0, 2};
    tbl[1] = '{1'b1, 32'h0000_4010, 32'h1234_5678, 32'h0000_0000, 3, 1'b0, 6};
    tbl[2] = '{1'b0, 32'h0000_1008, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b1, 3};
    tbl[3] = '{1'b1, 32'hABCD_0100, 32'h5555_AAAA, 32'h0000_0000, 1, 1'b0, 4};
    tbl[4] = '{1'b1, 32'h0000_0FF0, 32'h0F0F_0F0F, 32'h0000_0000, 1, 1'b1, 5};
    tbl[5] = '{1'b0, 32'h0001_2344, 32'h0000_0000, 32'h8765_4321, 2, 1'b0, 4};

    rst_n = 1'b0; hready_blk = 1'b0;
    bus.ahbls_hsel = 1'b0; bus.ahbls_htrans = 2'b00; bus.ahbls_haddr = 32'h0;
    bus.ahbls_hwrite = 1'b0; bus.ahbls_hsize = 3'd2; bus.ahbls_hwdata = 32'h0;
    bus.ahbls_hartid = 32'h0; bus.ahbls_pd_pc = 32'h0;
    bus.apbm_pready = 1'b0; bus.apbm_prdata = 32'h0; bus.apbm_pslverr = 1'b0;
    step(); step();
    chk("rst_psel", 32'(bus.apbm_psel), 32'h0);
    chk("rst_penable", 32'(bus.apbm_penable), 32'h0);
    chk("rst_pwrite", 32'(bus.apbm_pwrite), 32'h0);
    chk("rst_hready_resp", 32'(bus.ahbls_hready_resp), 32'h1);
    chk("rst_hresp", 32'(bus.ahbls_hresp), 32'h0);
    chk("rst_paddr", 32'(bus.apbm_paddr), 32'h0);
    chk("rst_pwdata", bus.apbm_pwdata, 32'h0);
    chk("rst_hrdata", bus.ahbls_hrdata, 32'h0);
    chk("rst_phartid", bus.apbm_phartid, 32'h0);
    chk("rst_pd_pc", bus.apbm_pd_pc, 32'h0);
    rst_n = 1'b1;
    step();

    // Directed vectors, issued back to back (later ones accepted in ERR2 / completion cycle)
    for (int i = 0; i < 6; i++) begin
      do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].nwait,
              tbl[i].err, tbl[i].exp_low);
    end

    idle_cycles(1'b1, 2'b00, 1'b0);
    idle_cycles(1'b1, 2'b01, 1'b0);
    idle_cycles(1'b0, 2'b10, 1'b0);
    idle_cycles(1'b1, 2'b10, 1'b1);

    // Reset asserted in the middle of an ACCESS wait
    bus.ahbls_hsel = 1'b1; bus.ahbls_htrans = 2'b10; bus.ahbls_haddr = 32'h0000_3000;
    bus.ahbls_hwrite = 1'b0;
    step();
    bus.ahbls_hsel = 1'b0; bus.ahbls_htrans = 2'b00; bus.apbm_pready = 1'b0;
    for (int i = 0; i < 6 && !(bus.apbm_psel && bus.apbm_penable); i++) step();
    chk("pre_rst_penable", 32'(bus.apbm_penable), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    hrdata_exp = 32'h0;
    chk("midrst_psel", 32'(bus.apbm_psel), 32'h0);
    chk("midrst_penable", 32'(bus.apbm_penable), 32'h0);
    chk("midrst_hready_resp", 32'(bus.ahbls_hready_resp), 32'h1);
    chk("midrst_hrdata", bus.ahbls_hrdata, hrdata_exp);
    step();
    rst_n = 1'b1;
    step();
    do_xfer(1'b0, 32'h0000_3000, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 3);

    // Randomized transfers against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom);
      err = ($urandom_range(0, 3) == 0);
      nw  = $urandom_range(0, 4);
      do_xfer(wr, $urandom, $urandom, $urandom, nw, err, (wr ? 3 : 2) + nw + int'(err));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
